// File: rtl/alpha_wb_arbiter.sv
// Two-master Wishbone classic arbiter. The grant is round-robin and held for the whole
// cycle; a slave timeout errors the owner so a dead slave cannot hang either master.
module alpha_wb_arbiter #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_we_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic [DW-1:0]   m0_dat_o,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_we_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic [DW-1:0]   m1_dat_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic            s_we_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  input  logic            s_ack_i,
  input  logic [DW-1:0]   s_dat_i,
  output logic [1:0]      grant_o,
  output logic            tmo_o
);

  localparam logic [1:0]  StIdle  = 2'd0;
  localparam logic [1:0]  StBusy  = 2'd1;
  localparam logic [1:0]  StTmo   = 2'd2;
  localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  grant_q, grant_d;
  logic        last_q, last_d;  // 1 when M1 was the most recent owner
  logic [15:0] cnt_q, cnt_d;

  logic            busy;
  logic            own_cyc, own_stb, own_we;
  logic [DW/8-1:0] own_sel;
  logic [AW-1:0]   own_adr;
  logic [DW-1:0]   own_dat;
  logic            tmo_hit;
  logic            pick_m1;

  // Outputs are gated by reset so an aborted transfer disappears in the reset cycle itself.
  assign busy    = (state_q == StBusy) && !wb_rst_i;

  assign own_cyc = grant_q[1] ? m1_cyc_i : m0_cyc_i;
  assign own_stb = grant_q[1] ? m1_stb_i : m0_stb_i;
  assign own_we  = grant_q[1] ? m1_we_i  : m0_we_i;
  assign own_sel = grant_q[1] ? m1_sel_i : m0_sel_i;
  assign own_adr = grant_q[1] ? m1_adr_i : m0_adr_i;
  assign own_dat = grant_q[1] ? m1_dat_i : m0_dat_i;

  assign s_cyc_o = busy && own_cyc;
  assign s_stb_o = s_cyc_o && own_stb;
  assign s_we_o  = busy && own_we;
  assign s_sel_o = busy ? own_sel : '0;
  assign s_adr_o = busy ? own_adr : '0;
  assign s_dat_o = busy ? own_dat : '0;

  // A same-cycle ack suppresses the timeout.
  assign tmo_hit = s_stb_o && !s_ack_i && (cnt_q == TmoLast);
  assign tmo_o   = tmo_hit;

  assign m0_ack_o = s_cyc_o && grant_q[0] && s_ack_i;
  assign m1_ack_o = s_cyc_o && grant_q[1] && s_ack_i;
  assign m0_err_o = tmo_hit && grant_q[0];
  assign m1_err_o = tmo_hit && grant_q[1];
  assign m0_dat_o = (busy && grant_q[0]) ? s_dat_i : '0;
  assign m1_dat_o = (busy && grant_q[1]) ? s_dat_i : '0;
  assign grant_o  = wb_rst_i ? 2'b00 : grant_q;

  assign pick_m1  = !(m0_cyc_i && (!m1_cyc_i || last_q));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i || m1_cyc_i) begin
          grant_d = pick_m1 ? 2'b10 : 2'b01;
          last_d  = pick_m1;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!own_cyc) begin
          grant_d = '0;
          cnt_d   = '0;
          state_d = StIdle;
        end else if (tmo_hit) begin
          cnt_d   = '0;
          state_d = StTmo;
        end else if (s_ack_i) begin
          cnt_d = '0;
        end else if (s_stb_o) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StTmo: begin
        if (!own_cyc) begin
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = '0;
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
